// File: rtl/laser_pkg.sv
// Types and constants shared by the laser transmit scheduler and the
// receiver-side frame parser.
package laser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECKSUM,
    ST_GAP
  } tx_sched_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/laser_tx_scheduler_stall_timer.sv
// Up-counter with synchronous clear and enable; tc_o flags the cycle whose
// increment would reach TIMEOUT, and the count wraps to zero there.
module stall_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (tc_o)  cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Frame sequencer: sync, header, payload, optional checksum, idle gap.
// Checksum pair is built only when LASER_TX_CHECKSUM_EN is defined.
module laser_tx_scheduler
  import laser_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data1,
  output logic [7:0]  tx_data2,
  output logic        tx_ready1,
  output logic        tx_ready2,
  output logic        tx_en,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

`ifdef LASER_TX_CHECKSUM_EN
  localparam tx_sched_state_t AFTER_PAYLOAD = ST_CHECKSUM;
`else
  localparam tx_sched_state_t AFTER_PAYLOAD = ST_GAP;
`endif

  tx_sched_state_t state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        err_q, err_d;
`ifdef LASER_TX_CHECKSUM_EN
  logic [7:0]  xor1_q, xor1_d, xor2_q, xor2_d;
`endif

  logic hold_load, stall_en, stall_clr, stall_tc;
  logic gap_en, gap_clr, gap_tc;
  logic tx_rdy;

  assign hold_load = (state_q == ST_PAYLOAD) && in_valid && !hold_vld_q;
  assign stall_en  = (state_q == ST_PAYLOAD) && !hold_vld_q;
  assign stall_clr = (state_q != ST_PAYLOAD) || hold_load;
  assign gap_en    = (state_q == ST_GAP);
  assign gap_clr   = (state_q != ST_GAP);

  stall_timer #(.TIMEOUT(TIMEOUT)) u_stall (
    .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(stall_clr), .en_i(stall_en), .tc_o(stall_tc)
  );

  stall_timer #(.TIMEOUT(GAP_CYCLES)) u_gap (
    .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(gap_clr), .en_i(gap_en), .tc_o(gap_tc)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    err_d      = err_q;
`ifdef LASER_TX_CHECKSUM_EN
    xor1_d     = xor1_q;
    xor2_d     = xor2_q;
`endif
    tx_rdy     = 1'b0;
    tx_en      = 1'b0;
    in_ready   = 1'b0;
    tx_data1   = '0;
    tx_data2   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef LASER_TX_CHECKSUM_EN
          xor1_d  = '0;
          xor2_d  = '0;
`endif
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        tx_en    = 1'b1;
        tx_rdy   = 1'b1;
        tx_data1 = SYNC_BYTE;
        tx_data2 = SYNC_BYTE;
        if (tx_done) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        tx_en    = 1'b1;
        tx_rdy   = 1'b1;
        tx_data1 = len_q;
        tx_data2 = ~len_q;
        if (tx_done) state_d = (len_q == '0) ? AFTER_PAYLOAD : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_en    = 1'b1;
        in_ready = !hold_vld_q;
        tx_rdy   = hold_vld_q;
        tx_data1 = hold_vld_q ? hold_q[15:8] : '0;
        tx_data2 = hold_vld_q ? hold_q[7:0]  : '0;
        if (hold_load) begin
          hold_d     = in_data;
          hold_vld_d = 1'b1;
        end else if (hold_vld_q && tx_done) begin
          hold_vld_d = 1'b0;
          cnt_d      = cnt_q + 8'd1;
`ifdef LASER_TX_CHECKSUM_EN
          xor1_d     = xor1_q ^ hold_q[15:8];
          xor2_d     = xor2_q ^ hold_q[7:0];
`endif
          // count is compared before increment so len=255 never needs a 9th bit
          if (cnt_q == len_q - 8'd1) state_d = AFTER_PAYLOAD;
        end else if (stall_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef LASER_TX_CHECKSUM_EN
      ST_CHECKSUM: begin
        tx_en    = 1'b1;
        tx_rdy   = 1'b1;
        tx_data1 = xor1_q;
        tx_data2 = xor2_q;
        if (tx_done) state_d = ST_GAP;
      end
`endif
      ST_GAP: begin
        if (gap_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_ready1  = tx_rdy;
  assign tx_ready2  = tx_rdy;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_GAP) && gap_tc;
  assign error      = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef LASER_TX_CHECKSUM_EN
      xor1_q     <= '0;
      xor2_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_q      <= err_d;
`ifdef LASER_TX_CHECKSUM_EN
      xor1_q     <= xor1_d;
      xor2_q     <= xor2_d;
`endif
    end
  end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Self-checking bench for laser_tx_scheduler; expected lane pairs come from a
// per-frame queue built from the frame rules, with randomized handshakes.
module tb_laser_tx_scheduler;
  import laser_pkg::*;

  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 64;

  typedef struct { logic [15:0] d; bit pay; } pair_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, tx_done = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] in_data = '0;
  logic        in_ready, tx_ready1, tx_ready2, tx_en, busy, frame_done, error;
  logic [7:0]  tx_data1, tx_data2;

  int unsigned n_vec = 0, n_err = 0;
  bit          sticky_err = 1'b0;
  logic [15:0] plan[$];

  always #5 clk = ~clk;

  laser_tx_scheduler #(
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO),
    .SYNC_BYTE (DEFAULT_SYNC_BYTE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_ready1(tx_ready1), .tx_ready2(tx_ready2),
    .tx_en(tx_en), .tx_done(tx_done), .busy(busy), .frame_done(frame_done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: n_sup < n_len means payload runs dry and an underrun abort is expected.
  // rst_after >= 0 pulls reset together with the tx_done of that payload pair.
  task automatic run_frame(input int unsigned n_len, input int unsigned n_sup,
                           input int unsigned dmin, input int unsigned dmax,
                           input int unsigned vprob, input bit hold_start, input int rst_after);
    pair_t       q[$];
    logic [7:0]  n8 = 8'(n_len);
    logic [7:0]  x1 = '0, x2 = '0;
    logic [15:0] cur = '0;
    bit          under = (n_sup < n_len);
    bit          presenting = 0, after_done = 0, fin = 0;
    int          cyc = 0, t_last = 0, sent = 0, pays_done = 0, src = 0;
    int unsigned delay = 0, wait_c = 0, d = 0;

    while (plan.size() < n_sup) plan.push_back(16'($urandom));
    q.push_back('{d: {DEFAULT_SYNC_BYTE, DEFAULT_SYNC_BYTE}, pay: 0});
    q.push_back('{d: {n8, ~n8}, pay: 0});
    for (int i = 0; i < int'(n_len); i++) begin
      q.push_back('{d: (i < int'(n_sup)) ? plan[i] : 16'hxxxx, pay: 1});
      if (i < int'(n_sup)) begin x1 ^= plan[i][15:8]; x2 ^= plan[i][7:0]; end
    end
`ifdef LASER_TX_CHECKSUM_EN
    if (!under) q.push_back('{d: {x1, x2}, pay: 0});
`endif

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_err", error, sticky_err);
    chk("idle_fd", frame_done, 0);
    chk("idle_txen", tx_en, 0);
    tx_done = 1'($urandom_range(0, 1));
    start   = 1'b1;
    len     = n8;
    in_valid = 1'b0;

    while (!fin) begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (!hold_start) start = 1'($urandom_range(0, 1));
      if (cyc > 30000) begin
        n_vec++; n_err++;
        $error("FAIL budget: frame len %0d still busy=%0b after %0d cycles", n_len, busy, cyc);
        break;
      end
      chk("lanes_eq", tx_ready2, tx_ready1);
      if (cyc == 1) begin
        chk("start_err_clr", error, 0);
        chk("sync_rise", {tx_en, tx_ready1, busy}, 3'b111);
        sticky_err = 1'b0;
      end
      if (after_done) begin
        after_done = 0;
        if (q.size() == 0) chk("gap_txen", tx_en, 0);
        else if (q[0].pay) begin
          chk("pay_wait", tx_ready1, 0);
          chk("inrdy_rise", in_ready, 1);
        end else chk("next_pair", tx_ready1, 1);
      end

      if (sent < 2 || pays_done >= int'(n_len)) chk("inrdy_off", in_ready, 0);
      if (src < int'(n_sup)) begin
        in_valid = ($urandom_range(1, 100) <= vprob);
        in_data  = in_valid ? plan[src] : 16'($urandom);
        if (in_valid && in_ready) src++;
      end else begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end

      if (q.size() == 0 && !under) begin
        d = cyc - t_last;
        tx_done = 1'($urandom_range(0, 1));
        if (frame_done) begin
          chk("fd_time", d, GAP);
          fin = 1;
        end else if (d > GAP) begin
          chk("fd_missing", frame_done, 1);
          fin = 1;
        end else begin
          chk("gap_outs", {tx_en, tx_ready1, busy}, 3'b001);
        end
      end else if (under && sent == 2 + int'(n_sup)) begin
        // starved cycles t_last+1 .. t_last+TMO, abort visible after them
        d = cyc - t_last;
        tx_done = 1'($urandom_range(0, 1));
        if (d == TMO + 1) begin
          chk("abort_outs", {error, busy, tx_en, frame_done}, 4'b1000);
          sticky_err = 1'b1;
          fin = 1;
        end else begin
          chk("starve_outs", {error, busy, tx_en, tx_ready1}, 4'b0110);
        end
      end else begin
        chk("fd_early", frame_done, 0);
        chk("busy_txen", {busy, tx_en}, 2'b11);
        if (tx_ready1) begin
          chk("rdy_inrdy", in_ready, 0);
          if (!presenting) begin
            presenting = 1;
            cur = {tx_data1, tx_data2};
            chk("pair", cur, q[0].d);
            delay  = $urandom_range(dmin, dmax);
            wait_c = 0;
          end else chk("stable", {tx_data1, tx_data2}, cur);
          if (wait_c == delay) begin
            if (rst_after >= 0 && q[0].pay && pays_done == rst_after) begin
              rst_n = 1'b0; tx_done = 1'b1; start = 1'b1;
              @(negedge clk);
              chk("rst_outs", {tx_en, tx_ready1, tx_ready2, in_ready, busy, frame_done,
                               error, tx_data1, tx_data2}, 0);
              rst_n = 1'b1;
              sticky_err = 1'b0;
              fin = 1;
            end else begin
              tx_done = 1'b1;
              if (q[0].pay) pays_done++;
              void'(q.pop_front());
              sent++;
              presenting = 0;
              t_last = cyc;
              after_done = 1;
            end
          end else wait_c++;
        end else begin
          chk("rdy_drop", presenting, 0);
          tx_done = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!hold_start) start = 1'b0;
    in_valid = 1'b0;
    tx_done  = 1'b0;
    plan.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {tx_en, tx_ready1, tx_ready2, in_ready, busy, frame_done,
                       error, tx_data1, tx_data2}, 0);
    rst_n = 1'b1;

    plan.push_back(16'h1234);
    plan.push_back(16'hC877);
    run_frame(2, 2, 3, 3, 100, 0, -1);

    run_frame(0, 0, 0, 3, 100, 0, -1);

    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(1, 20), 255, 0, $urandom_range(0, 4),
                $urandom_range(30, 100), 0, -1);

    run_frame(4, 4, 50, 50, 60, 0, -1);

    run_frame(3, 1, 0, 2, 100, 0, -1);
    run_frame(2, 2, 0, 2, 100, 0, -1);
    run_frame(5, 0, 0, 2, 100, 0, -1);
    run_frame(1, 1, 0, 0, 100, 0, -1);

    run_frame(10, 10, 0, 2, 80, 0, 5);
    run_frame(3, 3, 0, 2, 90, 0, -1);

    run_frame(2, 2, 0, 2, 100, 1, -1);
    run_frame(3, 3, 0, 2, 100, 1, -1);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stay_idle", busy, 0);
    end

    run_frame(255, 255, 0, 1, 100, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
